// File: rtl/pc_fetch_stage.sv
// PC register, instruction-memory fetch handshake and F/D pipeline register.
// Holds F_PC, fetches over req/ready, and presents the D-stage instruction.
module pc_fetch_stage #(
  localparam int unsigned XLEN  = 32,
  localparam int unsigned EXC_W = 5,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [XLEN-1:0] IM_LO    = 32'h0000_3000,
  parameter logic [XLEN-1:0] IM_HI    = 32'h0000_6FFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  NPC,
  input  logic             stall,
  input  logic             flush_d,
  output logic             im_req,
  output logic [XLEN-1:0]  im_addr,
  input  logic             im_ready,
  input  logic [XLEN-1:0]  im_rdata,
  output logic [XLEN-1:0]  F_PC,
  output logic [XLEN-1:0]  D_PC,
  output logic [XLEN-1:0]  D_instr,
  output logic             D_valid,
  output logic [EXC_W-1:0] D_exc,
  output logic             fetch_busy
);

  localparam logic [EXC_W-1:0] EXC_ADEL = EXC_W'(4);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] buf_q;

  logic             in_fetch;
  logic             legal;
  logic             avail;
  logic             advance;
  logic             capture;
  logic [XLEN-1:0]  instr_c;
  logic [EXC_W-1:0] exc_c;

  // Fetch-address legality and instruction-availability decode
  assign in_fetch = (state_q == FETCH);
  assign legal    = (F_PC[1:0] == 2'b00) && (F_PC >= IM_LO) && (F_PC <= IM_HI);
  assign avail    = in_fetch ? (!legal || im_ready) : 1'b1;
  assign advance  = avail && !stall;
  assign capture  = in_fetch && legal && im_ready && stall;

  // Illegal fetches inject a nop carrying AdEL; HOLD replays the buffered word
  assign instr_c = !in_fetch ? buf_q : (legal ? im_rdata : '0);
  assign exc_c   = (in_fetch && !legal) ? EXC_ADEL : '0;

  // Request and busy are gated by reset so nothing is issued while it is low
  assign im_req     = reset && in_fetch && legal;
  assign fetch_busy = reset && in_fetch && legal && !im_ready;
  assign im_addr    = F_PC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      buf_q   <= '0;
      F_PC    <= RESET_PC;
      D_PC    <= '0;
      D_instr <= '0;
      D_valid <= 1'b0;
      D_exc   <= '0;
    end else begin
      if (advance) begin
        F_PC    <= NPC;
        state_q <= FETCH;
      end else if (capture) begin
        buf_q   <= im_rdata;
        state_q <= HOLD;
      end

      // A flush bubbles D regardless of hold or load; D_PC is left as is
      if (flush_d) begin
        D_instr <= '0;
        D_valid <= 1'b0;
        D_exc   <= '0;
      end else if (advance) begin
        D_PC    <= F_PC;
        D_instr <= instr_c;
        D_valid <= 1'b1;
        D_exc   <= exc_c;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed vector bench for pc_fetch_stage: per-cycle input/expected table
// plus a hand-written asynchronous-reset-mid-wait sequence.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] NPC = '0;
  logic        stall = 1'b0;
  logic        flush_d = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready = 1'b0;
  logic [31:0] im_rdata = '0;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic        D_valid;
  logic [4:0]  D_exc;
  logic        fetch_busy;

  int n_vec = 0;
  int n_bad = 0;

  pc_fetch_stage dut (
    .clk(clk), .reset(reset), .NPC(NPC), .stall(stall), .flush_d(flush_d),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
    .F_PC(F_PC), .D_PC(D_PC), .D_instr(D_instr), .D_valid(D_valid),
    .D_exc(D_exc), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  // One row = inputs held for a cycle, outputs expected just before its rising edge
  typedef struct packed {
    logic        rst;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic        rdy;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] dinstr;
    logic        dvalid;
    logic [4:0]  dexc;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [31:0] npc, input logic stl,
                     input logic fl, input logic rdy, input logic [31:0] rdata,
                     input logic req, input logic [31:0] fpc, input logic [31:0] dpc,
                     input logic [31:0] di, input logic dv, input logic [4:0] de,
                     input logic busy);
    vec_t v;
    v = '{rst, npc, stl, fl, rdy, rdata, req, fpc, dpc, di, dv, de, busy};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic req, input logic [31:0] fpc,
                       input logic [31:0] dpc, input logic [31:0] di, input logic dv,
                       input logic [4:0] de, input logic busy);
    n_vec++;
    if (im_req !== req || im_addr !== fpc || F_PC !== fpc || D_PC !== dpc ||
        D_instr !== di || D_valid !== dv || D_exc !== de || fetch_busy !== busy) begin
      n_bad++;
      $display("FAIL %s: got req=%0b addr=%h fpc=%h dpc=%h instr=%h valid=%0b exc=%0d busy=%0b; want req=%0b addr=%h fpc=%h dpc=%h instr=%h valid=%0b exc=%0d busy=%0b",
               name, im_req, im_addr, F_PC, D_PC, D_instr, D_valid, D_exc, fetch_busy,
               req, fpc, fpc, dpc, di, dv, de, busy);
    end
  endtask

  initial begin
    //   rst npc           stl fl rdy rdata          req fpc           dpc           instr         v  exc busy
    add(0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h3000, 32'h0,    32'h0,        0, 0, 0); // reset
    add(1, 32'h3004,     0, 0, 1, 32'h24010001, 1, 32'h3000, 32'h0,    32'h0,        0, 0, 0); // first req
    add(1, 32'h3008,     0, 0, 0, 32'hDEADBEEF, 1, 32'h3004, 32'h3000, 32'h24010001, 1, 0, 1); // wait 1
    add(1, 32'h3008,     0, 0, 0, 32'hDEADBEEF, 1, 32'h3004, 32'h3000, 32'h24010001, 1, 0, 1); // wait 2
    add(1, 32'h3008,     0, 0, 0, 32'hDEADBEEF, 1, 32'h3004, 32'h3000, 32'h24010001, 1, 0, 1); // wait 3
    add(1, 32'h3008,     0, 0, 1, 32'h24020002, 1, 32'h3004, 32'h3000, 32'h24010001, 1, 0, 0); // ready
    add(1, 32'h300C,     1, 0, 1, 32'h24030003, 1, 32'h3008, 32'h3004, 32'h24020002, 1, 0, 0); // stall on ready
    add(1, 32'h300C,     1, 0, 1, 32'hBAD0BAD0, 0, 32'h3008, 32'h3004, 32'h24020002, 1, 0, 0); // HOLD, no req
    add(1, 32'h300C,     0, 0, 0, 32'h0,        0, 32'h3008, 32'h3004, 32'h24020002, 1, 0, 0); // release
    add(1, 32'h3400,     0, 0, 1, 32'h24040004, 1, 32'h300C, 32'h3008, 32'h24030003, 1, 0, 0); // branch delay slot
    add(1, 32'h3002,     0, 0, 1, 32'h24050005, 1, 32'h3400, 32'h300C, 32'h24040004, 1, 0, 0); // at target
    add(1, 32'h7000,     0, 0, 1, 32'hFFFFFFFF, 0, 32'h3002, 32'h3400, 32'h24050005, 1, 0, 0); // misaligned
    add(1, 32'h3010,     1, 0, 0, 32'h0,        0, 32'h7000, 32'h3002, 32'h0,        1, 4, 0); // above HI, stalled
    add(1, 32'h3010,     0, 0, 0, 32'h0,        0, 32'h7000, 32'h3002, 32'h0,        1, 4, 0); // above HI, free
    add(1, 32'h3014,     0, 0, 0, 32'h0,        1, 32'h3010, 32'h7000, 32'h0,        1, 4, 1); // waiting
    add(1, 32'h3014,     1, 1, 1, 32'h24060006, 1, 32'h3010, 32'h7000, 32'h0,        1, 4, 0); // stall+flush on ready
    add(1, 32'h3014,     1, 1, 0, 32'h0,        0, 32'h3010, 32'h7000, 32'h0,        0, 0, 0); // HOLD kept, bubble
    add(1, 32'h3014,     0, 1, 0, 32'h0,        0, 32'h3010, 32'h7000, 32'h0,        0, 0, 0); // advance+flush
    add(1, 32'h3018,     0, 0, 1, 32'h24070007, 1, 32'h3014, 32'h7000, 32'h0,        0, 0, 0); // word dropped
    add(1, 32'h6FFC,     0, 0, 1, 32'h24080008, 1, 32'h3018, 32'h3014, 32'h24070007, 1, 0, 0);
    add(1, 32'h3000,     0, 0, 0, 32'h0,        1, 32'h6FFC, 32'h3018, 32'h24080008, 1, 0, 1); // top legal word
    add(1, 32'h2FFC,     0, 0, 1, 32'h24090009, 1, 32'h6FFC, 32'h3018, 32'h24080008, 1, 0, 0);
    add(1, 32'h3000,     0, 0, 0, 32'h0,        0, 32'h2FFC, 32'h6FFC, 32'h24090009, 1, 0, 0); // below LO
    add(1, 32'h3004,     0, 0, 0, 32'h0,        1, 32'h3000, 32'h2FFC, 32'h0,        1, 4, 1); // pending req

    foreach (vq[i]) begin
      @(negedge clk);
      reset    = vq[i].rst;
      NPC      = vq[i].npc;
      stall    = vq[i].stall;
      flush_d  = vq[i].flush;
      im_ready = vq[i].rdy;
      im_rdata = vq[i].rdata;
      #1;
      check($sformatf("vec%0d", i), vq[i].req, vq[i].fpc, vq[i].dpc, vq[i].dinstr,
            vq[i].dvalid, vq[i].dexc, vq[i].busy);
    end

    // Asynchronous reset mid-wait: outputs must clear without a clock edge
    @(posedge clk);
    #2;
    check("pre_async_reset", 1'b1, 32'h3000, 32'h2FFC, 32'h0, 1'b1, 5'd4, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset", 1'b0, 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    NPC      = 32'h3004;
    im_ready = 1'b1;
    im_rdata = 32'h240A000A;
    #1;
    check("first_req_after_reset", 1'b1, 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    im_ready = 1'b0;
    NPC      = 32'h3008;
    #1;
    check("restart_load", 1'b1, 32'h3004, 32'h3000, 32'h240A000A, 1'b1, 5'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

PC register, instruction-fetch handshake and F/D pipeline register of the P6 pipeline. The block holds `F_PC`, fetches the instruction at `F_PC` from instruction memory over a req/ready handshake, and loads `NPC` (from the next-PC unit) into `F_PC` on every advance. It supplies `F_PC` and `D_PC` back to the next-PC unit and presents the D-stage instruction to the decoder and comparator.

## Interface
- `RESET_PC`, default 32'h0000_3000: `F_PC` value after reset.
- `IM_LO`, default 32'h0000_3000: lowest legal fetch address, inclusive.
- `IM_HI`, default 32'h0000_6FFF: highest legal fetch address, inclusive.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low; low forces every register to its reset value immediately.
- `NPC` input 32: next PC from the next-PC unit.
- `stall` input 1: hazard-unit freeze of F and D.
- `flush_d` input 1: convert D into a bubble.
- `im_req` output 1: fetch request.
- `im_addr` output 32: fetch address, equal to `F_PC`.
- `im_ready` input 1: `im_rdata` valid this cycle; completes the request.
- `im_rdata` input 32: fetched instruction word.
- `F_PC` output 32: fetch PC.
- `D_PC` output 32: PC of the D-stage instruction.
- `D_instr` output 32: D-stage instruction; 0 (nop) for bubbles.
- `D_valid` output 1: D holds a real instruction.
- `D_exc` output 5: D-stage exception code; 0 = none, 4 = AdEL on fetch.
- `fetch_busy` output 1: fetch outstanding; the hazard unit ORs this into `stall`.

## Operation
- Legal address: `F_PC[1:0]==0` and `IM_LO <= F_PC <= IM_HI`, both compares unsigned.
- FSM states:
  - FETCH: `im_req = legal`.
  - HOLD: instruction captured in a 32-bit buffer; `im_req = 0`.
- "Instruction available" (`avail`) is any one of:
  - FETCH and legal and `im_ready`, using `im_rdata`;
  - FETCH and illegal, using 0 with exc 4; no request is issued;
  - HOLD, using the buffer.
- `fetch_busy = (state==FETCH) && legal && !im_ready`; it is combinational and does not depend on `stall`.
- Advance = `avail && !stall`. On advance:
  - `F_PC <= NPC`;
  - D loads {`F_PC`, instruction, `D_valid`=1, exc};
  - state becomes FETCH.
- FETCH with `im_ready && stall`: buffer <= `im_rdata`, state becomes HOLD, `F_PC` holds.
- With no `avail`, or with `stall`: `F_PC` and D hold.
- `flush_d`:
  - D becomes a bubble: `D_instr`=0, `D_valid`=0, `D_exc`=0; `D_PC` keeps its old value.
  - It takes priority over both hold and load of D.
  - On a cycle that also advances, `F_PC` still takes `NPC` and the fetched word is dropped.
- `NPC` is sampled only on advance. The branch/jump target is resolved from `D_PC` in the same cycle the delay-slot instruction advances, so no fetch-side flush is needed for branches.
- `im_addr` is stable while `im_req` is high, because `F_PC` changes only on advance.
- `im_ready` is ignored when `im_req` is 0.

## Timing
- Reset values:
  - `F_PC`=`RESET_PC`, `D_PC`=0, `D_instr`=0, `D_valid`=0, `D_exc`=0;
  - state FETCH, buffer 0;
  - `im_req` forced 0 while `reset` is low.
- First `im_req` is asserted in the first cycle after `reset` deasserts.
- Zero-wait memory (`im_ready` in the request cycle): one instruction per cycle, fetch-to-D latency 1 cycle.
- N wait cycles: `fetch_busy` is high for N cycles and D holds for those cycles.
- Stall arriving in the `im_ready` cycle: the word is buffered; with the buffer there is no re-fetch and no lost word. D updates in the first cycle with `stall`=0.
- Reset mid-request: the outstanding request is abandoned. The memory shares `reset` and must cancel its own transaction.
- Simultaneous events:
  - `stall` and `flush_d`: F holds, D is a bubble, HOLD is preserved.
  - Illegal `F_PC` with `stall`: D holds; the AdEL bubble enters D on the first unstalled cycle.

## Test plan
- Reset, then zero-wait memory returning 0x24010001, 0x24020002: `F_PC` is 0x3000, 0x3004, 0x3008; `D_PC`/`D_instr` are 0x3000/0x24010001, then 0x3004/0x24020002; `D_valid`=1.
- `im_ready` delayed 3 cycles at 0x3004: `fetch_busy`=1 for 3 cycles, `im_addr` holds 0x3004, D holds the 0x3000 instruction, then loads the 0x3004 instruction.
- `stall`=1 in the `im_ready` cycle for 0x3008 and held 2 cycles: state is HOLD, `im_req`=0, no new request; on release D gets 0x3008 with the buffered word; the next request is at `NPC`.
- `NPC`=0x3400 on advance from 0x3004 (taken branch): the delay slot 0x3004 enters D, then `F_PC` becomes 0x3400.
- `NPC`=0x3002 then 0x7000: no `im_req`; D gets `D_instr`=0, `D_exc`=4, `D_valid`=1 with `D_PC`=0x3002, then the same with `D_PC`=0x7000.
- `flush_d` together with `stall`: D becomes a bubble and `F_PC` is unchanged. Async reset pulled low mid-wait: all outputs take their reset values immediately and `im_req`=0.
